ram_port_arbiter: RTL and testbench

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

---
 rtl/ram_port_arbiter_pkg.sv | 14 +
 rtl/ram_port_arbiter_if.sv | 30 +++
 rtl/ram_port_arbiter_rr_select.sv | 37 +++
 rtl/ram_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_ram_port_arbiter.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_port_arbiter_pkg.sv
// Shared definitions for the RAM port arbiter.
//   arb_state_e : arbiter FSM states (normal arbitration, draining, host-owned)
//   WordShift   : byte-to-word address shift for the 32-bit block RAM
package ram_port_arbiter_pkg;

  typedef enum logic [1:0] {
    StArb   = 2'd0,
    StDrain = 2'd1,
    StHost  = 2'd2
  } arb_state_e;

  localparam int unsigned WordShift = 2;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester-side bus of the RAM port arbiter.
//   req_valid/req_write/req_address/req_write_data : per-requester access, slice i = requester i
//   req_ready  : one-hot grant, same cycle as the access
//   resp_valid : one-hot completion (read data or misalignment error) one cycle later
//   resp_data/resp_error : shared completion payload
// master = the requesters, slave = the arbiter.
interface ram_port_arbiter_if #(
  parameter int unsigned WORD_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 16,
  parameter int unsigned NUM_REQ       = 4
);
  logic [NUM_REQ-1:0]               req_valid;
  logic [NUM_REQ-1:0]               req_write;
  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_address;
  logic [NUM_REQ*WORD_WIDTH-1:0]    req_write_data;
  logic [NUM_REQ-1:0]               req_ready;
  logic [NUM_REQ-1:0]               resp_valid;
  logic [WORD_WIDTH-1:0]            resp_data;
  logic                             resp_error;

  modport master (
    output req_valid, req_write, req_address, req_write_data,
    input  req_ready, resp_valid, resp_data, resp_error
  );

  modport slave (
    input  req_valid, req_write, req_address, req_write_data,
    output req_ready, resp_valid, resp_data, resp_error
  );
endinterface

// File: rtl/ram_port_arbiter_rr_select.sv
// Round-robin selector.
//   request : request vector
//   pointer : highest-priority index this cycle
//   grant   : one-hot grant (zero when nothing requests)
//   index   : binary index of the granted requester
//   valid   : a grant was made
module rr_select #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned IDX_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]   request,
  input  logic [IDX_WIDTH-1:0] pointer,
  output logic [NUM_REQ-1:0]   grant,
  output logic [IDX_WIDTH-1:0] index,
  output logic                 valid
);

  always_comb begin
    int unsigned ptr_u;
    int unsigned slot;
    grant = '0;
    index = '0;
    valid = 1'b0;
    ptr_u = 32'(pointer);
    slot  = 0;
    // First requester found walking upward from pointer (wrapping) wins.
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      slot = (ptr_u + k) % NUM_REQ;
      if (!valid && request[slot]) begin
        grant[slot] = 1'b1;
        index       = IDX_WIDTH'(slot);
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates NUM_REQ shader-core requesters and a lockable host port onto one block RAM.
//   clock, reset_n          : clock and synchronous active-low reset
//   req_bus (slave)         : requester accesses, one-hot grant, one-cycle-later completions
//   host_lock_req/grant     : host exclusive-ownership handshake
//   host_address/write/...  : host access, passed straight to the RAM while owned
//   ram_*                   : word-addressed block RAM port, read data one cycle after address
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int unsigned WORD_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 16,
  parameter int unsigned NUM_REQ       = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  ram_port_arbiter_if.slave        req_bus,
  input  logic                     host_lock_req,
  output logic                     host_lock_grant,
  input  logic [ADDRESS_WIDTH-1:0] host_address,
  input  logic                     host_write,
  input  logic [WORD_WIDTH-1:0]    host_write_data,
  output logic [ADDRESS_WIDTH-1:0] ram_address,
  output logic                     ram_write,
  output logic [WORD_WIDTH-1:0]    ram_write_data,
  input  logic [WORD_WIDTH-1:0]    ram_read_data
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  arb_state_e          state_q, state_d;
  logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]  pend_valid_q, pend_valid_d;
  logic                pend_error_q, pend_error_d;
  logic                host_lock_grant_q;

  logic                grant_enable;
  logic [NUM_REQ-1:0]  sel_grant;
  logic [IdxW-1:0]     sel_index;
  logic                sel_valid;

  logic [ADDRESS_WIDTH-1:0] g_address;
  logic                     g_write;
  logic [WORD_WIDTH-1:0]    g_write_data;
  logic                     g_misaligned;

  // A rising lock request blocks grants in the very same cycle.
  assign grant_enable = reset_n && (state_q == StArb) && !host_lock_req;

  rr_select #(
    .NUM_REQ   (NUM_REQ),
    .IDX_WIDTH (IdxW)
  ) u_rr_select (
    .request (req_bus.req_valid & {NUM_REQ{grant_enable}}),
    .pointer (rr_ptr_q),
    .grant   (sel_grant),
    .index   (sel_index),
    .valid   (sel_valid)
  );

  assign req_bus.req_ready = sel_grant;

  always_comb begin
    g_address    = '0;
    g_write      = 1'b0;
    g_write_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (sel_grant[i]) begin
        g_address    = req_bus.req_address[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        g_write      = req_bus.req_write[i];
        g_write_data = req_bus.req_write_data[i*WORD_WIDTH +: WORD_WIDTH];
      end
    end
  end

  assign g_misaligned = |g_address[1:0];

  // RAM port mux: host while owned, else the granted requester, else idle zeros.
  always_comb begin
    ram_address    = '0;
    ram_write      = 1'b0;
    ram_write_data = '0;
    if (reset_n) begin
      if (state_q == StHost) begin
        ram_address    = host_address >> WordShift;
        ram_write      = host_write;
        ram_write_data = host_write_data;
      end else if (sel_valid) begin
        ram_address    = g_address >> WordShift;
        ram_write      = g_write && !g_misaligned;
        ram_write_data = g_write_data;
      end
    end
  end

  // Reads and any misaligned access complete in the next cycle.
  always_comb begin
    pend_valid_d = '0;
    pend_error_d = 1'b0;
    if (sel_valid && (!g_write || g_misaligned)) begin
      pend_valid_d = sel_grant;
      pend_error_d = g_misaligned;
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (sel_valid) begin
      rr_ptr_d = (sel_index == IdxW'(NUM_REQ - 1)) ? '0 : sel_index + 1'b1;
    end
  end

  // No grant is made in the cycle the lock is requested, so the only response
  // that can still be outstanding is the one delivered during that cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StArb:   if (host_lock_req) state_d = (|pend_valid_d) ? StDrain : StHost;
      StDrain: state_d = host_lock_req ? StHost : StArb;
      StHost:  if (!host_lock_req) state_d = StArb;
      default: state_d = StArb;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q           <= StArb;
      rr_ptr_q          <= '0;
      pend_valid_q      <= '0;
      pend_error_q      <= 1'b0;
      host_lock_grant_q <= 1'b0;
    end else begin
      state_q           <= state_d;
      rr_ptr_q          <= rr_ptr_d;
      pend_valid_q      <= pend_valid_d;
      pend_error_q      <= pend_error_d;
      host_lock_grant_q <= (state_d == StHost);
    end
  end

  assign host_lock_grant = host_lock_grant_q;

  // Gated by reset_n so a completion already registered is dropped when reset lands.
  assign req_bus.resp_valid = pend_valid_q & {NUM_REQ{reset_n}};
  assign req_bus.resp_error = pend_error_q && reset_n;
  assign req_bus.resp_data  = (reset_n && (|pend_valid_q) && !pend_error_q) ? ram_read_data : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;
  localparam int WW = 32;
  localparam int AW = 16;
  localparam int N  = 4;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          host_lock_req, host_lock_grant, host_write;
  logic [AW-1:0] host_address, ram_address;
  logic [WW-1:0] host_write_data, ram_write_data;
  logic          ram_write;
  logic [WW-1:0] ram_read_data = '0;

  ram_port_arbiter_if #(.WORD_WIDTH(WW), .ADDRESS_WIDTH(AW), .NUM_REQ(N)) bus ();

  ram_port_arbiter #(.WORD_WIDTH(WW), .ADDRESS_WIDTH(AW), .NUM_REQ(N)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .req_bus         (bus.slave),
    .host_lock_req   (host_lock_req),
    .host_lock_grant (host_lock_grant),
    .host_address    (host_address),
    .host_write      (host_write),
    .host_write_data (host_write_data),
    .ram_address     (ram_address),
    .ram_write       (ram_write),
    .ram_write_data  (ram_write_data),
    .ram_read_data   (ram_read_data)
  );

  always #5 clock = ~clock;

  // Block RAM: read-first, one-cycle read latency.
  logic [WW-1:0] mem [64];
  always @(posedge clock) begin
    ram_read_data <= mem[ram_address[5:0]];
    if (ram_write) mem[ram_address[5:0]] <= ram_write_data;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit            m_started = 0;
  int            m_rr = 0;
  bit            m_hlg = 0;   // host owns the RAM this cycle
  bit            m_pv = 0;
  int            m_pidx = 0;
  bit            m_perr = 0;
  logic [WW-1:0] m_pdata = '0;
  logic [WW-1:0] m_mem [64];

  function automatic int model_pick();
    if (reset_n !== 1'b1 || host_lock_req || m_hlg) return -1;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_rr + k) % N;
      if (bus.req_valid[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [AW-1:0] addr_of(input int i);
    return bus.req_address[i*AW +: AW];
  endfunction

  always @(posedge clock) begin
    int g;
    logic [AW-1:0] a;
    bit mis, w;
    if (!reset_n) begin
      m_started = 1;
      m_rr = 0; m_pv = 0; m_hlg = 0;
    end else begin
      g = model_pick();
      m_pv = 0;
      if (g >= 0) begin
        a   = addr_of(g);
        mis = (a % 4) != 0;
        w   = bus.req_write[g];
        m_rr = (g + 1) % N;
        if (!w || mis) begin
          m_pv = 1; m_pidx = g; m_perr = mis;
          m_pdata = m_mem[(a / 4) % 64];
        end
        if (w && !mis) m_mem[(a / 4) % 64] = bus.req_write_data[g*WW +: WW];
      end
      if (m_hlg && host_write) m_mem[(host_address / 4) % 64] = host_write_data;
      m_hlg = host_lock_req;
    end
  end

  // Per-cycle comparison against the model, late in the low phase.
  always @(negedge clock) begin
    int g;
    logic [AW-1:0] a;
    #3;
    if (m_started) begin
      g = model_pick();
      chk("ready", bus.req_ready, (g >= 0) ? (64'd1 << g) : 64'd0);
      chk("resp_valid", bus.resp_valid, (reset_n && m_pv) ? (64'd1 << m_pidx) : 64'd0);
      chk("resp_error", bus.resp_error, reset_n && m_pv && m_perr);
      if (reset_n && m_pv && !m_perr) chk("resp_data", bus.resp_data, m_pdata);
      chk("hlg", host_lock_grant, m_hlg);
      if (!reset_n) begin
        chk("ram_idle_rst", {ram_address, ram_write, ram_write_data}, '0);
      end else if (m_hlg) begin
        chk("host_addr", ram_address, host_address / 4);
        chk("host_we", ram_write, host_write);
        chk("host_wd", ram_write_data, host_write_data);
      end else if (g >= 0) begin
        a = addr_of(g);
        chk("ram_addr", ram_address, a / 4);
        chk("ram_we", ram_write, bus.req_write[g] && (a % 4) == 0);
        if (bus.req_write[g] && (a % 4) == 0)
          chk("ram_wd", ram_write_data, bus.req_write_data[g*WW +: WW]);
      end else begin
        chk("ram_idle", {ram_address, ram_write, ram_write_data}, '0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    bus.req_valid = '0; bus.req_write = '0; bus.req_address = '0; bus.req_write_data = '0;
    host_lock_req = 0; host_write = 0; host_address = '0; host_write_data = '0;
  endtask

  task automatic set_req(input int i, input bit w, input logic [AW-1:0] a, input logic [WW-1:0] d);
    bus.req_valid[i] = 1'b1;
    bus.req_write[i] = w;
    bus.req_address[i*AW +: AW] = a;
    bus.req_write_data[i*WW +: WW] = d;
  endtask

  task automatic all_reads();
    for (int j = 0; j < N; j++) set_req(j, 1'b0, AW'(16'h40 + 4 * j), '0);
  endtask

  int lock_hold;

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i] = 32'h0101_0101 * i;
      m_mem[i] = 32'h0101_0101 * i;
    end
    idle();
    reset_n = 0;
    repeat (2) @(negedge clock);
    #2;
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_hlg", host_lock_grant, 0);
    chk("rst_resp", bus.resp_valid, 0);

    @(negedge clock); reset_n = 1; idle();

    // Round-robin walk from pointer 0.
    for (int i = 0; i < 4; i++) begin
      @(negedge clock); idle(); all_reads();
      #2 chk("rr_seq", bus.req_ready, 64'd1 << i);
    end
    @(negedge clock); idle(); all_reads();
    #2 chk("rr_wrap", bus.req_ready, 4'b0001);

    // Write then read back through requester 2.
    @(negedge clock); idle(); set_req(2, 1'b1, 16'h0010, 32'hCAFE_F00D);
    #2 chk("wr_addr", ram_address, 16'h0004);
    chk("wr_we", ram_write, 1);
    chk("wr_data", ram_write_data, 32'hCAFE_F00D);
    @(negedge clock); idle(); set_req(2, 1'b0, 16'h0010, '0);
    #2 chk("rd_addr", ram_address, 16'h0004);
    chk("rd_we", ram_write, 0);
    @(negedge clock); idle();
    #2 chk("rd_rv", bus.resp_valid, 4'b0100);
    chk("rd_data", bus.resp_data, 32'hCAFE_F00D);
    chk("rd_err", bus.resp_error, 0);

    // Misaligned read and write.
    @(negedge clock); idle(); set_req(1, 1'b0, 16'h0006, '0);
    #2 chk("mis_rd_we", ram_write, 0);
    @(negedge clock); idle(); set_req(3, 1'b1, 16'h000A, 32'hDEAD_BEEF);
    #2 chk("mis_wr_we", ram_write, 0);
    chk("mis_rd_rv", bus.resp_valid, 4'b0010);
    chk("mis_rd_err", bus.resp_error, 1);
    @(negedge clock); idle();
    #2 chk("mis_wr_rv", bus.resp_valid, 4'b1000);
    chk("mis_wr_err", bus.resp_error, 1);

    // Host lock with a read in flight.
    @(negedge clock); idle(); set_req(0, 1'b0, 16'h0020, '0);
    #2 chk("lk_grant0", bus.req_ready, 4'b0001);
    @(negedge clock); idle(); set_req(0, 1'b0, 16'h0024, '0); set_req(1, 1'b0, 16'h0028, '0);
    host_lock_req = 1;
    #2 chk("lk_noready", bus.req_ready, 0);
    chk("lk_resp", bus.resp_valid, 4'b0001);
    chk("lk_hlg_t1", host_lock_grant, 0);
    @(negedge clock); host_address = 16'h0020; host_write = 1; host_write_data = 32'h1234_5678;
    #2 chk("lk_hlg_t2", host_lock_grant, 1);
    chk("host_addr_lit", ram_address, 16'h0008);
    chk("host_we_lit", ram_write, 1);
    @(negedge clock); host_write = 0; host_lock_req = 0;
    #2 chk("host_mem", mem[8], 32'h1234_5678);
    chk("lk_hold_ready", bus.req_ready, 0);
    @(negedge clock); idle(); all_reads();
    #2 chk("unlk_hlg", host_lock_grant, 0);
    chk("unlk_rr", bus.req_ready, 4'b0010);

    // Reset with a read in flight.
    @(negedge clock); idle(); set_req(3, 1'b0, 16'h0030, '0);
    #2 chk("rst_rd_ready", bus.req_ready, 4'b1000);
    @(negedge clock); idle(); reset_n = 0; all_reads();
    #2 chk("rst_mid_rv", bus.resp_valid, 0);
    chk("rst_mid_ready", bus.req_ready, 0);
    @(negedge clock); idle(); reset_n = 1;
    #2 chk("rst_after_rv", bus.resp_valid, 0);
    chk("rst_after_hlg", host_lock_grant, 0);
    @(negedge clock); idle(); all_reads();
    #2 chk("rst_rr0", bus.req_ready, 4'b0001);

    // Mixed traffic with occasional lock windows.
    lock_hold = 0;
    repeat (300) begin
      @(negedge clock); idle();
      for (int j = 0; j < N; j++)
        if ($urandom_range(0, 2) != 0)
          set_req(j, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 255)), $urandom);
      if (lock_hold == 0 && $urandom_range(0, 15) == 0) lock_hold = $urandom_range(1, 5);
      if (lock_hold > 0) begin
        host_lock_req = 1;
        lock_hold--;
      end
      host_write = 1'($urandom_range(0, 1));
      host_address = AW'($urandom_range(0, 255));
      host_write_data = $urandom;
    end

    @(negedge clock); idle();
    repeat (3) @(negedge clock);
    #4;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
